// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the control decoder.
//
// Owns the PC and runs a req/ack handshake with a variable-latency
// instruction memory. The fetched word is held in an instruction
// register (IR) and offered to decode with a valid/ready handshake.
// Branch/jump redirects from the datapath squash any fetch in flight.
//
// Optional feature: define FETCH_TIMEOUT_EN to bound how long a request
// may wait for ack. When the bound expires the unit parks in S_ERR and
// raises a sticky fetch_err until rst. Without the macro the unit has no
// counter and no S_ERR, and fetch_err is tied low.
//
// Parameters:
//   PC_RESET        PC loaded on reset (bits [1:0] must be 0)
//   TIMEOUT_CYCLES  waiting cycles allowed before timeout (feature only)
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req/imem_addr        fetch request and word-aligned address
//   imem_ack/imem_rdata       memory response, data valid with ack
//   redirect_en/redirect_pc   taken branch/jump and its target
//   id_ready                  decode consumes the current instruction
//   inst_valid/inst_word      IR holds an unconsumed instruction / IR
//   inst/func                 opcode [31:26] and function [5:0] of IR
//   pc_out/pc_plus4           address of the IR instruction and +4
//   fetch_err                 sticky fetch timeout flag
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_REQ   | request outstanding at imem_addr, waiting for imem_ack
// S_VALID | IR holds an instruction offered to decode
// S_ERR   | fetch timed out; parked until rst (FETCH_TIMEOUT_EN only)

module fetch_unit #(
  parameter logic [31:0] PC_RESET       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        inst_valid,
  output logic [31:0] inst_word,
  output logic [5:0]  inst,
  output logic [5:0]  func,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1
`ifdef FETCH_TIMEOUT_EN
    , S_ERR = 2'd2
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_out_q, pc_out_d;
  // kill_q marks the outstanding request as stale after a redirect;
  // addr_q keeps that stale address on the bus until its ack arrives,
  // while pc_q already tracks the newest redirect target.
  logic        kill_q, kill_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] redirect_target;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);

  // Down-counter of waiting cycles left; reloaded whenever not waiting.
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  // Inputs intentionally ignored (low target bits are forced to zero).
  logic unused_bits;
`ifdef FETCH_TIMEOUT_EN
  assign unused_bits = ^redirect_pc[1:0];
`else
  assign unused_bits = ^{redirect_pc[1:0], TIMEOUT_CYCLES};
`endif

  assign redirect_target = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= PC_RESET;
      ir_q     <= '0;
      pc_out_q <= PC_RESET;
      kill_q   <= 1'b0;
      addr_q   <= PC_RESET;
`ifdef FETCH_TIMEOUT_EN
      tmo_q    <= TMO_LOAD;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      pc_out_q <= pc_out_d;
      kill_q   <= kill_d;
      addr_q   <= addr_d;
`ifdef FETCH_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    pc_out_d = pc_out_q;
    kill_d   = kill_q;
    addr_d   = addr_q;
`ifdef FETCH_TIMEOUT_EN
    tmo_d    = TMO_LOAD;
    err_d    = err_q;
`endif

    unique case (state_q)
      S_REQ: begin
        if (redirect_en) begin
          pc_d = redirect_target;
          if (imem_ack) begin
            // Response belongs to the pre-redirect path: drop it.
            kill_d = 1'b0;
          end else begin
            // First redirect freezes the bus address; later ones only
            // move pc_q, so a single discard stays pending.
            if (!kill_q) addr_d = pc_q;
            kill_d = 1'b1;
          end
        end else if (imem_ack) begin
          if (kill_q) begin
            kill_d = 1'b0;
          end else begin
            ir_d     = imem_rdata;
            pc_out_d = pc_q;
            state_d  = S_VALID;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_q == TMO_W'(1)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
`endif
      end

      S_VALID: begin
        if (redirect_en) begin
          pc_d    = redirect_target;
          state_d = S_REQ;
        end else if (id_ready) begin
          pc_d    = pc_plus4;
          state_d = S_REQ;
        end
      end

`ifdef FETCH_TIMEOUT_EN
      S_ERR: state_d = S_ERR;
`endif

      default: state_d = S_REQ;
    endcase
  end

  assign imem_req   = (state_q == S_REQ) & ~rst;
  assign imem_addr  = kill_q ? addr_q : pc_q;
  assign inst_valid = (state_q == S_VALID) & ~rst;
  assign inst_word  = ir_q;
  assign inst       = ir_q[31:26];
  assign func       = ir_q[5:0];
  assign pc_out     = pc_out_q;
  assign pc_plus4   = pc_out_q + 32'd4;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err  = err_q & ~rst;
`else
  assign fetch_err  = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the control decoder.
- Owns the PC register and runs a req/ack handshake with instruction memory (variable latency).
- Holds the fetched word in an instruction register (IR) and presents opcode/func fields plus PC to decode with a valid/ready handshake.
- Accepts branch/jump redirects from the datapath and squashes in-flight fetches.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
TIMEOUT_CYCLES, 16, max cycles a request may wait for ack (used only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  word-aligned fetch address
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  instruction word, valid when imem_ack=1
redirect_en  in  1  branch-taken/jump: load redirect_pc
redirect_pc  in  32  redirect target; bits [1:0] ignored
id_ready  in  1  decode consumes current instruction this cycle
inst_valid  out  1  IR holds an unconsumed instruction
inst_word  out  32  IR contents
inst  out  6  opcode, inst_word[31:26]
func  out  6  function field, inst_word[5:0]
pc_out  out  32  address of the instruction in IR
pc_plus4  out  32  pc_out + 4, modulo 2^32
fetch_err  out  1  sticky fetch timeout flag (0 when feature compiled out)

Behaviour:
- Reset (rst=1 at an edge):
  - pc=PC_RESET, IR=0, pc_out=PC_RESET, kill=0, state=S_REQ.
  - Outputs: inst_valid=0, imem_req=0 in the reset cycle, fetch_err=0.
- States:
  - S_REQ: imem_req=1, imem_addr=pc.
  - S_VALID: imem_req=0, inst_valid=1.
  - S_ERR: feature only.
- S_REQ:
  - imem_req and imem_addr are held stable until imem_ack is sampled high.
  - On ack with kill=0: IR<=imem_rdata, pc_out<=pc, state<=S_VALID. inst_valid rises the next cycle, so the minimum latency is 1 cycle from the request cycle.
  - On ack with kill=1: data discarded, kill<=0, stay in S_REQ. The new request at the redirected pc is issued the next cycle.
- S_VALID:
  - If id_ready: pc<=pc_out+4 and state<=S_REQ; inst_valid drops the next cycle.
  - If not id_ready: IR, pc_out and inst_valid hold.
- redirect_en (any state, highest priority):
  - pc<={redirect_pc[31:2],2'b00}.
  - In S_VALID: inst_valid<=0, state<=S_REQ. This applies regardless of id_ready; the consumed branch is not re-presented.
  - In S_REQ with no ack this cycle: kill<=1. The request stays on the old address until ack, per the handshake rule.
  - In S_REQ with ack in the same cycle: returned data discarded, kill<=0, state stays S_REQ with the new pc.
  - Repeated redirects while kill=1: the latest target wins; a single discard is still pending.
- Arithmetic:
  - pc increments by 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
  - pc[1:0] is always 0.
- inst and func are combinational slices of IR. Consumers must qualify them with inst_valid; IR holds stale data when inst_valid=0.
- Reset mid-request: the pending transaction is abandoned; any ack arriving after reset during the first S_REQ is treated as the response to the PC_RESET request.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter runs while imem_req=1 and imem_ack=0.
  - When it reaches TIMEOUT_CYCLES: imem_req<=0, state<=S_ERR, fetch_err<=1 (sticky), inst_valid=0.
  - S_ERR exits only via rst. The counter clears on ack or redirect.
- Undefined: no counter and no S_ERR; fetch_err is tied 0 and requests wait indefinitely.

Test Plan:
1. Reset, imem acks 1 cycle after every request, id_ready=1, memory returns 32'h0000_0020 at addr 0 -> imem_addr 0,4,8 in sequence; after the first ack, inst_valid=1, inst=6'h00, func=6'h20, pc_out=0, pc_plus4=4.
2. Hold id_ready=0 for 5 cycles while IR holds word 32'h8C22_0004 -> inst=6'h23 stable, inst_valid=1, imem_req=0; a single id_ready pulse yields exactly one next request at pc_out+4.
3. In S_VALID at pc=0x40, pulse redirect_en with redirect_pc=0x103 -> inst_valid falls, next imem_addr=0x100.
4. Redirect to 0x200 while a request to 0x44 awaits ack (ack 3 cycles later) -> 0x44 data never reaches IR (inst_valid stays 0); next request is 0x200.
5. Set PC_RESET=32'hFFFF_FFFC with sequential fetch -> second imem_addr=0x0; redirect coincident with ack is also discarded.
6. With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, and ack withheld -> imem_req drops and fetch_err=1 after 16 waiting cycles; fetch_err stays 1 until rst, then 0.
